// File: rtl/tile_iter_ctrl.sv
// Tile iteration controller: walks a layer as K-group-outer / pixel-inner tiles
// and presents one valid/ready tile descriptor per cycle at sustained ready.
module tile_iter_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       layer_type,
  input  logic [CNT_W-1:0] tile_n,
  input  logic [CNT_W-1:0] total_n,
  input  logic [7:0]       out_C,
  input  logic [7:0]       tile_K,
  input  logic             tile_ready,
  output logic             tile_valid,
  output logic [CNT_W-1:0] n_base,
  output logic [CNT_W-1:0] n_len,
  output logic [7:0]       k_base,
  output logic [7:0]       k_len,
  output logic             last_tile,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] tile_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, FIN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       type_q;
  logic [CNT_W-1:0] tile_n_q, total_n_q, n_base_q, tile_cnt_q;
  logic [7:0]       out_c_q, tile_k_q, k_base_q;
  logic             rej_q;

  logic [CNT_W:0]   n_rem, n_end;
  logic [CNT_W-1:0] n_len_raw;
  logic [8:0]       k_rem, k_end;
  logic [7:0]       k_len_raw;
  logic             n_wrap, k_wrap, issue, xfer, last, reject;

  // Remainders and end points are one bit wider so total_n near 2^CNT_W cannot wrap.
  always_comb begin
    n_rem     = {1'b0, total_n_q} - {1'b0, n_base_q};
    n_len_raw = ({1'b0, tile_n_q} < n_rem) ? tile_n_q : n_rem[CNT_W-1:0];
    n_end     = {1'b0, n_base_q} + {1'b0, n_len_raw};
    n_wrap    = (n_end == {1'b0, total_n_q});
    k_rem     = {1'b0, out_c_q} - {1'b0, k_base_q};
    k_len_raw = ({1'b0, tile_k_q} < k_rem) ? tile_k_q : k_rem[7:0];
    k_end     = {1'b0, k_base_q} + {1'b0, k_len_raw};
    k_wrap    = (k_end == {1'b0, out_c_q});
  end

  assign issue  = (state_q == ISSUE);
  assign xfer   = issue && tile_ready;
  assign last   = issue && n_wrap && k_wrap;
  assign reject = (tile_n_q == '0) || (total_n_q == '0) || (out_c_q == '0) ||
                  (tile_k_q == '0) || ((type_q == 2'd0) && (tile_n_q[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = CHECK;
      CHECK: state_d = reject ? FIN : ISSUE;
      ISSUE: if (xfer && last) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      type_q     <= '0;
      tile_n_q   <= '0;
      total_n_q  <= '0;
      out_c_q    <= '0;
      tile_k_q   <= '0;
      n_base_q   <= '0;
      k_base_q   <= '0;
      tile_cnt_q <= '0;
      rej_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          type_q     <= layer_type;
          tile_n_q   <= tile_n;
          total_n_q  <= total_n;
          out_c_q    <= out_C;
          tile_k_q   <= tile_K;
          tile_cnt_q <= '0;
          rej_q      <= 1'b0;
        end
        CHECK: begin
          rej_q    <= reject;
          n_base_q <= '0;
          k_base_q <= '0;
        end
        ISSUE: if (xfer) begin
          tile_cnt_q <= tile_cnt_q + CNT_W'(1);
          if (!last) begin
            if (n_wrap) begin
              n_base_q <= '0;
              k_base_q <= k_base_q + tile_k_q;
            end else begin
              n_base_q <= n_base_q + tile_n_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tile_valid = issue;
  assign n_base     = n_base_q;
  assign n_len      = issue ? n_len_raw : '0;
  assign k_base     = k_base_q;
  assign k_len      = issue ? k_len_raw : '0;
  assign last_tile  = last;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign err        = (state_q == FIN) && rej_q;
  assign tile_cnt   = tile_cnt_q;

endmodule

// File: doc/tile_iter_ctrl.md
TILE_ITER_CTRL -- requirements
Module: tile_iter_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the pixel-count, tile-size and tile-counter fields.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a layer; sampled only in IDLE.
REQ-005 SHALL have port layer_type  input  2  0=PW, 1=DW, 2=STD, 3=LIN.
REQ-006 SHALL have port tile_n  input  CNT_W  max pixels per tile, from the tile-size calculator.
REQ-007 SHALL have port total_n  input  CNT_W  total output pixels of the layer.
REQ-008 SHALL have port out_C  input  8  output channels.
REQ-009 SHALL have port tile_K  input  8  output channels per K-group.
REQ-010 SHALL have port tile_ready  input  1  downstream accepts the current tile descriptor.
REQ-011 SHALL have port tile_valid  output  1  a tile descriptor is presented.
REQ-012 SHALL have port n_base / n_len  output  CNT_W each  first pixel and pixel count of the tile.
REQ-013 SHALL have port k_base / k_len  output  8 each  first output channel and channel count of the tile.
REQ-014 SHALL have port last_tile  output  1  the presented tile is the final one of the layer.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at the end of the layer.
REQ-017 SHALL have port err  output  1  one-cycle pulse, coincident with done, when the layer is rejected.
REQ-018 SHALL have port tile_cnt  output  CNT_W  number of tiles accepted in the current or most recent layer.

Function
REQ-019 SHALL implement the FSM IDLE -> CHECK -> ISSUE -> FIN -> IDLE.
REQ-020 IDLE, start=1: SHALL latch layer_type, tile_n, total_n, out_C and tile_K, clear tile_cnt, and go to CHECK; later input changes SHALL have no effect until the next start.
REQ-021 CHECK SHALL last exactly one cycle and SHALL reject the layer if the latched tile_n, total_n, out_C or tile_K is 0, or if layer_type=PW and tile_n[1:0]!=0.
REQ-022 A rejected layer SHALL go to FIN, issue no tiles and pulse err with done; an accepted layer SHALL set n_base=0 and k_base=0 and go to ISSUE.
REQ-023 First tile_valid SHALL be high two cycles after the start cycle.
REQ-024 Iteration order SHALL be K-group outer and pixel inner: n_base steps by tile_n through total_n, then resets to 0 while k_base steps by tile_K.
REQ-025 n_len SHALL equal min(tile_n, total_n - n_base), with the comparison done at CNT_W+1 bits so there is no overflow.
REQ-026 k_len SHALL equal min(tile_K, out_C - k_base), with the comparison done at 9 bits.
REQ-027 last_tile SHALL be high when n_base+n_len==total_n and k_base+k_len==out_C.
REQ-028 A tile SHALL transfer on any cycle with tile_valid=1 and tile_ready=1.
REQ-029 With tile_valid=1 and tile_ready=0, all descriptor outputs SHALL stay stable and tile_valid SHALL not drop.
REQ-030 On a non-last transfer, the FSM SHALL stay in ISSUE and present the next tile in the following cycle, giving one tile per cycle at sustained ready.
REQ-031 Every transfer SHALL increment tile_cnt by 1; tile_cnt SHALL hold its value after done until the next start.
REQ-032 On the last transfer, tile_valid SHALL drop in the next cycle and the FSM SHALL enter FIN.
REQ-033 FIN SHALL pulse done for exactly one cycle and return to IDLE.
REQ-034 start outside IDLE SHALL be ignored; start in the same cycle as the FIN pulse SHALL be ignored.
REQ-035 tile_ready while tile_valid=0 SHALL be ignored.
REQ-036 layer_type SHALL affect only the alignment check; DW, STD and LIN SHALL iterate identically.

Reset
REQ-037 With rst_n=0 at a clock edge, the block SHALL go to IDLE with tile_valid, busy, done, err and last_tile at 0 and n_base, n_len, k_base, k_len and tile_cnt at 0.
REQ-038 Reset during ISSUE SHALL abort the layer with no done pulse; the first start after reset SHALL begin a fresh layer.

Verification
REQ-039 The bench SHALL cover: tile_n=8, total_n=20, out_C=16, tile_K=16, ready=1 -> tiles (n_base,n_len) = (0,8),(8,8),(16,4) on consecutive cycles, last_tile on the third, done next cycle, tile_cnt=3.
REQ-040 The bench SHALL cover: tile_n=4, total_n=4, out_C=20, tile_K=8 -> k tiles (0,8),(8,8),(16,4), tile_cnt=3.
REQ-041 The bench SHALL cover: ready held low 5 cycles on the first tile -> descriptor stable and valid held for 5 cycles, no skipped or duplicated tile.
REQ-042 The bench SHALL cover: layer_type=PW, tile_n=6 -> no tile_valid, done and err pulse together 2 cycles after start, tile_cnt=0.
REQ-043 The bench SHALL cover: start pulsed during ISSUE, then rst_n=0 for one cycle mid-layer -> start ignored, all outputs 0, no done; a new start runs a complete layer.
REQ-044 The bench SHALL cover: total_n=0xFFFFFFFF, tile_n=0x80000000 -> n_len values 0x80000000 then 0x7FFFFFFF, with no wrap.
